// File: rtl/disp_pkg.sv
`timescale 1ns/1ps
// disp_pkg: shared types and constants for the seven-segment BCD output port.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   state_t          - conversion controller state (IDLE, CONV)
//   BCD_W            - width of the double-dabble accumulator (5 digits)
//   DIGITS           - number of digits driven onto the display
//   ERR_PATTERN_DEF  - default dataout value for out-of-range decimal writes
package disp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // Five BCD digits are needed to hold any 16-bit input (max 65535).
    localparam int BCD_W  = 20;
    localparam int DIGITS = 4;

    localparam logic [15:0] ERR_PATTERN_DEF = 16'hEEEE;

endpackage

// File: rtl/bcd_digit_adj.sv
`timescale 1ns/1ps
// bcd_digit_adj: double-dabble digit correction, adds 3 to a BCD digit >= 5.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   din   - 4-bit BCD digit before the shift
//   dout  - corrected digit, so the following left shift carries correctly
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/disp_bcd_port.sv
`timescale 1ns/1ps
// disp_bcd_port: memory-mapped hex / binary-to-BCD output port for a 4-digit display.
// Latency: hex write visible 1 cycle after the write edge; decimal write 16 cycles after.
// Backpressure: none; a new write always wins and restarts or aborts a conversion.
//
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   bus_addr     - CPU address; HEX_ADDR = raw hex write, DEC_ADDR = binary-to-decimal write
//   bus_wdata    - CPU write data
//   bus_we       - single-cycle write strobe
//   dataout      - registered digit nibbles, MSB nibble on the leftmost digit
//   busy         - high for the 16 cycles of a decimal conversion
//   overflow     - last decimal write was above 9999 (display shows ERR_PATTERN)
//   bus_re       - read strobe            (only with DISP_READBACK_EN)
//   bus_rdata    - registered read data   (only with DISP_READBACK_EN)
//
// Build option: define DISP_READBACK_EN to add the read-back ports.
module disp_bcd_port
    import disp_pkg::*;
#(
    parameter logic [15:0] HEX_ADDR    = 16'hFF00,
    parameter logic [15:0] DEC_ADDR    = 16'hFF01,
    parameter logic [15:0] ERR_PATTERN = ERR_PATTERN_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bus_addr,
    input  logic [15:0] bus_wdata,
    input  logic        bus_we,
    output logic [15:0] dataout,
    output logic        busy,
    output logic        overflow
`ifdef DISP_READBACK_EN
    ,
    input  logic        bus_re,
    output logic [15:0] bus_rdata
`endif
);

    localparam int NDIG_ACC = BCD_W / 4;
    localparam int DISP_W   = DIGITS * 4;

    state_t             state;
    logic [15:0]        sreg;
    logic [BCD_W-1:0]   bcd;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   bcd_nxt;
    logic [3:0]         cnt;

    logic               hex_wr;
    logic               dec_wr;
    logic               last_bit;
    logic               too_big;

    assign hex_wr = bus_we && (bus_addr == HEX_ADDR);
    assign dec_wr = bus_we && (bus_addr == DEC_ADDR);

    // Correct every accumulator digit, then shift the next input bit in.
    for (genvar g = 0; g < NDIG_ACC; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (bcd[4*g +: 4]),
            .dout (adj[4*g +: 4])
        );
    end

    assign bcd_nxt  = {adj[BCD_W-2:0], sreg[15]};
    assign last_bit = (cnt == 4'd15);

    // Anything in the fifth digit means the value did not fit in four digits.
    // adj[BCD_W-1] can only be set if the accumulator itself overflowed; folding it
    // in keeps the check robust should the input width ever grow.
    assign too_big = (bcd_nxt[BCD_W-1:DISP_W] != '0) || adj[BCD_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sreg     <= '0;
            bcd      <= '0;
            cnt      <= '0;
            dataout  <= '0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else if (hex_wr) begin
            // Raw write also cancels any conversion in flight.
            dataout  <= bus_wdata;
            overflow <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
        end else if (dec_wr) begin
            // Starts (or restarts) a conversion; dataout keeps showing the old value.
            sreg     <= bus_wdata;
            bcd      <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= CONV;
        end else begin
            case (state)
                CONV: begin
                    bcd  <= bcd_nxt;
                    sreg <= {sreg[14:0], 1'b0};
                    cnt  <= cnt + 4'd1;
                    if (last_bit) begin
                        if (too_big) begin
                            dataout  <= ERR_PATTERN;
                            overflow <= 1'b1;
                        end else begin
                            dataout  <= bcd_nxt[DISP_W-1:0];
                            overflow <= 1'b0;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DISP_READBACK_EN
    // Read data is registered: it reflects the state seen on the read edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_rdata <= '0;
        end else if (bus_re && (bus_addr == HEX_ADDR)) begin
            bus_rdata <= dataout;
        end else if (bus_re && (bus_addr == DEC_ADDR)) begin
            bus_rdata <= {14'b0, overflow, busy};
        end else begin
            bus_rdata <= '0;
        end
    end
`else
    // Write-only build: no read path.
`endif

endmodule

// File: doc/disp_bcd_port.md
Name: disp_bcd_port

Overview:
- Memory-mapped output port sitting directly upstream of the 4-digit seven-segment driver.
- Its dataout feeds the driver's 16-bit nibble input; each nibble is one digit, MSB nibble on the leftmost digit.
- The CPU writes either a raw hex word (passed through) or a binary value that is converted to 4-digit BCD.
- Conversion is sequential shift-and-add-3 (double dabble), one bit per cycle, with a busy flag.

Parameters:
- HEX_ADDR, 16'hFF00: bus address for a raw hex write.
- DEC_ADDR, 16'hFF01: bus address for a binary-to-decimal write.
- ERR_PATTERN, 16'hEEEE: dataout value shown when the decimal value exceeds 9999.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- bus_addr  input  16  CPU address.
- bus_wdata  input  16  CPU write data.
- bus_we  input  1  write strobe, single-cycle, sampled on posedge clk.
- dataout  output  16  digit nibbles to the display driver; registered.
- busy  output  1  high while a decimal conversion is in progress.
- overflow  output  1  sticky flag: last decimal write was above 9999.

Behaviour:
- One clock, clk; reset is synchronous and active-high (port rst). All state changes on posedge clk.
- Reset values:
  - dataout=16'h0000, busy=0, overflow=0, state=IDLE.
  - Internal shift register, BCD accumulator and bit counter cleared.
- Reset mid-conversion aborts it; dataout returns to 0.
- A write is accepted when bus_we=1 and bus_addr matches; any other address is ignored.
- Hex write:
  - Edge N: dataout<=bus_wdata, overflow<=0, busy<=0, state<=IDLE.
  - Latency 1 cycle. A hex write during a conversion aborts the conversion.
- Decimal write:
  - Edge N: sreg<=bus_wdata, bcd(20 bits)<=0, cnt<=0, state<=CONV, busy<=1.
  - dataout holds its previous value throughout the conversion.
- States: IDLE, CONV.
- CONV, each edge:
  - Every 4-bit digit of bcd that is >=5 gets +3.
  - Then bcd<={adjusted[18:0], sreg[15]}, sreg<=sreg<<1, cnt<=cnt+1.
  - cnt is 4 bits.
- Completion, on the edge where cnt==15 (edge N+16):
  - If the final bcd[19:16]!=0: dataout<=ERR_PATTERN and overflow<=1.
  - Otherwise: dataout<=bcd[15:0] and overflow<=0.
  - On the same edge: busy<=0, state<=IDLE.
  - busy is high for exactly 16 cycles; result is visible 16 cycles after the write edge.
- A decimal write while busy restarts the conversion with the new value; the earlier value never appears.
- Writes on the completion edge take priority over completion: a new write wins.
- Range limits: 0 -> 16'h0000; 9999 -> 16'h9999; 10000..65535 -> ERR_PATTERN.

Optional Feature:
- Macro: DISP_READBACK_EN.
- Defined:
  - Adds ports bus_re (input 1) and bus_rdata (output 16).
  - A read of HEX_ADDR returns dataout on the next cycle.
  - A read of DEC_ADDR returns {14'b0, overflow, busy} on the next cycle.
  - bus_rdata is 0 otherwise; reset value is 0.
- Undefined: no read ports; the block is write-only.

Decomposition:
- Package disp_pkg holds:
  - state enum (IDLE, CONV);
  - BCD_W=20 and DIGITS=4 constants;
  - the default ERR_PATTERN value.
- One sub-module, bcd_digit_adj: combinational, 4-bit in, 4-bit out, adds 3 when the input is >=5. Instantiated 5 times in a generate loop.
- Control and datapath stay in the top module.

Test Plan:
- Reset, then a decimal write of 16'h04D2 (1234):
  - busy=1 for 16 cycles;
  - dataout=16'h1234 at write edge +16;
  - overflow=0.
- Hex write of 16'hBEEF: dataout=16'hBEEF one cycle later, busy stays 0.
- Decimal writes of 9999, then 10000, then 65535:
  - 9999 -> 16'h9999, overflow=0;
  - 10000 -> 16'hEEEE, overflow=1;
  - 65535 -> 16'hEEEE, overflow=1.
- Decimal write of 500, then a decimal write of 42 at cycle +5:
  - 500 (16'h0500) never appears;
  - dataout=16'h0042 at second write +16.
- Decimal write of 777, then a hex write of 16'h00A5 at cycle +8: dataout=16'h00A5 next cycle, busy=0, no later update.
- Assert rst at cycle +10 of a conversion: the next cycle shows dataout=0, busy=0, overflow=0. With DISP_READBACK_EN, a read of DEC_ADDR returns 16'h0000.
